writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage.sv | 152 +++++++++++++++
 tb/tb_writeback_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: MEM/WB pipeline latch, load-data extraction, register-file
// write control and a retired-instruction counter.
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   stall, flush        latch hold / bubble insertion (flush wins)
//   in_*                MEM-stage slot captured into the latch
//   wb_write_enable     register-file write strobe
//   wb_write_register   register-file write index (latched rd, always driven)
//   wb_write_data       register-file write data
//   wb_valid            latched slot is a real instruction
//   wb_exception        latched load is misaligned or has an illegal funct3
//   retire_count        count of retired instructions (wraps)
module writeback_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [4:0]  in_rd,
    input  logic        in_reg_write,
    input  logic [1:0]  in_wb_sel,
    input  logic [63:0] in_alu_result,
    input  logic [63:0] in_mem_rdata,
    input  logic [2:0]  in_funct3,
    input  logic [2:0]  in_addr_lo,
    input  logic [63:0] in_pc_plus4,
    output logic        wb_write_enable,
    output logic [4:0]  wb_write_register,
    output logic [63:0] wb_write_data,
    output logic        wb_valid,
    output logic        wb_exception,
    output logic [63:0] retire_count
);

    localparam int unsigned XLEN = 64;
    localparam int unsigned REGW = 5;

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_LINK = 2'b10;

    logic            valid_q;
    logic [REGW-1:0] rd_q;
    logic            reg_write_q;
    logic [1:0]      wb_sel_q;
    logic [XLEN-1:0] alu_q;
    logic [XLEN-1:0] rdata_q;
    logic [2:0]      funct3_q;
    logic [2:0]      addr_lo_q;
    logic [XLEN-1:0] pc4_q;
    logic [XLEN-1:0] retire_q;

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_data;
    logic            misaligned;
    logic            illegal;
    logic            exception;

    // MEM/WB latch; flush forces a bubble even while the other fields hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            wb_sel_q    <= '0;
            alu_q       <= '0;
            rdata_q     <= '0;
            funct3_q    <= '0;
            addr_lo_q   <= '0;
            pc4_q       <= '0;
        end else begin
            if (!stall) begin
                valid_q     <= in_valid;
                rd_q        <= in_rd;
                reg_write_q <= in_reg_write;
                wb_sel_q    <= in_wb_sel;
                alu_q       <= in_alu_result;
                rdata_q     <= in_mem_rdata;
                funct3_q    <= in_funct3;
                addr_lo_q   <= in_addr_lo;
                pc4_q       <= in_pc_plus4;
            end
            if (flush) begin
                valid_q <= 1'b0;
            end
        end
    end

    // Load extraction: shift the addressed byte down to bit 0, then size/extend
    always_comb begin
        shifted    = rdata_q >> {addr_lo_q, 3'b000};
        load_data  = '0;
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (funct3_q)
            3'b000: load_data = {{56{shifted[7]}}, shifted[7:0]};
            3'b001: begin
                load_data  = {{48{shifted[15]}}, shifted[15:0]};
                misaligned = addr_lo_q[0];
            end
            3'b010: begin
                load_data  = {{32{shifted[31]}}, shifted[31:0]};
                misaligned = (addr_lo_q[1:0] != 2'b00);
            end
            3'b011: begin
                load_data  = shifted;
                misaligned = (addr_lo_q != 3'b000);
            end
            3'b100: load_data = {56'd0, shifted[7:0]};
            3'b101: begin
                load_data  = {48'd0, shifted[15:0]};
                misaligned = addr_lo_q[0];
            end
            3'b110: begin
                load_data  = {32'd0, shifted[31:0]};
                misaligned = (addr_lo_q[1:0] != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
    end

    assign exception = valid_q & (wb_sel_q == SEL_LOAD) & (misaligned | illegal);

    // Result mux and write control
    always_comb begin
        wb_write_data = '0;
        case (wb_sel_q)
            SEL_ALU:  wb_write_data = alu_q;
            SEL_LOAD: wb_write_data = load_data;
            SEL_LINK: wb_write_data = pc4_q;
            default:  wb_write_data = '0;
        endcase
    end

    assign wb_write_enable   = valid_q & reg_write_q & (rd_q != '0) & ~exception
                               & (wb_sel_q != 2'b11);
    assign wb_write_register = rd_q;
    assign wb_valid          = valid_q;
    assign wb_exception      = exception;

    // A slot retires on the edge it leaves the latch, so a stall counts it once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_q <= '0;
        end else if (valid_q && !stall && !exception) begin
            retire_q <= retire_q + XLEN'(1);
        end
    end

    assign retire_count = retire_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed testbench for writeback_stage with hand-computed expectations.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic [1:0]  in_wb_sel;
    logic [63:0] in_alu_result;
    logic [63:0] in_mem_rdata;
    logic [2:0]  in_funct3;
    logic [2:0]  in_addr_lo;
    logic [63:0] in_pc_plus4;
    logic        wb_write_enable;
    logic [4:0]  wb_write_register;
    logic [63:0] wb_write_data;
    logic        wb_valid;
    logic        wb_exception;
    logic [63:0] retire_count;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_cnt;

    writeback_stage dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .flush             (flush),
        .in_valid          (in_valid),
        .in_rd             (in_rd),
        .in_reg_write      (in_reg_write),
        .in_wb_sel         (in_wb_sel),
        .in_alu_result     (in_alu_result),
        .in_mem_rdata      (in_mem_rdata),
        .in_funct3         (in_funct3),
        .in_addr_lo        (in_addr_lo),
        .in_pc_plus4       (in_pc_plus4),
        .wb_write_enable   (wb_write_enable),
        .wb_write_register (wb_write_register),
        .wb_write_data     (wb_write_data),
        .wb_valid          (wb_valid),
        .wb_exception      (wb_exception),
        .retire_count      (retire_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%016h expected=0x%016h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic rw,
                         input logic [1:0] sel, input logic [63:0] alu,
                         input logic [63:0] rdata, input logic [2:0] f3,
                         input logic [2:0] a, input logic [63:0] pc4);
        in_valid      = v;
        in_rd         = rd;
        in_reg_write  = rw;
        in_wb_sel     = sel;
        in_alu_result = alu;
        in_mem_rdata  = rdata;
        in_funct3     = f3;
        in_addr_lo    = a;
        in_pc_plus4   = pc4;
    endtask

    task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [2:0] a,
                        input logic [63:0] rdata);
        drive(1'b1, rd, 1'b1, 2'b01, 64'h0, rdata, f3, a, 64'h0);
    endtask

    task automatic bubble();
        drive(1'b0, 5'd0, 1'b0, 2'b00, 64'h0, 64'h0, 3'd0, 3'd0, 64'h0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_we"},   64'(wb_write_enable), 64'd0);
        check({tag, "_reg"},  64'(wb_write_register), 64'd0);
        check({tag, "_data"}, wb_write_data, 64'd0);
        check({tag, "_valid"}, 64'(wb_valid), 64'd0);
        check({tag, "_exc"},  64'(wb_exception), 64'd0);
        check({tag, "_cnt"},  retire_count, 64'd0);
    endtask

    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b1, 5'd9, 1'b1, 2'b00, 64'h77, 64'h0, 3'd0, 3'd0, 64'h0);
        #3;
        check_zero("reset");
        tick();
        tick();
        check_zero("reset_hold");
        rst = 1'b0;
        exp_cnt = 64'd0;

        // LB, byte 1 of 0x80FF is 0x80 -> sign-extended
        load(5'd5, 3'b000, 3'd1, 64'h0000_0000_0000_80FF);
        tick();
        check("lb_we",   64'(wb_write_enable), 64'd1);
        check("lb_reg",  64'(wb_write_register), 64'd5);
        check("lb_data", wb_write_data, 64'hFFFF_FFFF_FFFF_FF80);
        check("lb_valid", 64'(wb_valid), 64'd1);
        check("lb_exc",  64'(wb_exception), 64'd0);
        check("lb_cnt",  retire_count, exp_cnt);

        load(5'd6, 3'b101, 3'd2, 64'h1234_5678_9ABC_DEF0);
        tick(); exp_cnt++;
        check("lhu_data", wb_write_data, 64'h0000_0000_0000_9ABC);
        check("lhu_cnt",  retire_count, exp_cnt);

        load(5'd7, 3'b010, 3'd4, 64'h8000_0001_0000_0000);
        tick(); exp_cnt++;
        check("lw_data", wb_write_data, 64'hFFFF_FFFF_8000_0001);
        check("lw_we",   64'(wb_write_enable), 64'd1);

        load(5'd8, 3'b100, 3'd7, 64'h9900_0000_0000_0000);
        tick(); exp_cnt++;
        check("lbu_data", wb_write_data, 64'h0000_0000_0000_0099);

        load(5'd8, 3'b011, 3'd0, 64'hDEAD_BEEF_CAFE_F00D);
        tick(); exp_cnt++;
        check("ld_data", wb_write_data, 64'hDEAD_BEEF_CAFE_F00D);

        load(5'd8, 3'b110, 3'd0, 64'h0000_0000_F000_0000);
        tick(); exp_cnt++;
        check("lwu_data", wb_write_data, 64'h0000_0000_F000_0000);

        load(5'd8, 3'b001, 3'd6, 64'h8001_0000_0000_0000);
        tick(); exp_cnt++;
        check("lh_data", wb_write_data, 64'hFFFF_FFFF_FFFF_8001);
        check("lh_cnt",  retire_count, exp_cnt);

        // misaligned LW: exception, no write, not retired
        load(5'd9, 3'b010, 3'd2, 64'h1111_2222_3333_4444);
        tick(); exp_cnt++;
        check("mis_exc", 64'(wb_exception), 64'd1);
        check("mis_we",  64'(wb_write_enable), 64'd0);
        check("mis_valid", 64'(wb_valid), 64'd1);

        // ALU op to x0: no write, but retires
        drive(1'b1, 5'd0, 1'b1, 2'b00, 64'h1234, 64'h0, 3'd0, 3'd0, 64'h0);
        tick();
        check("mis_cnt",  retire_count, exp_cnt);
        check("x0_we",    64'(wb_write_enable), 64'd0);
        check("x0_data",  wb_write_data, 64'h1234);

        drive(1'b1, 5'd1, 1'b1, 2'b10, 64'h0, 64'h0, 3'd0, 3'd0, 64'h8000_0004);
        tick(); exp_cnt++;
        check("x0_cnt",    retire_count, exp_cnt);
        check("link_data", wb_write_data, 64'h8000_0004);
        check("link_we",   64'(wb_write_enable), 64'd1);
        check("link_reg",  64'(wb_write_register), 64'd1);

        load(5'd2, 3'b111, 3'd0, 64'h55);
        tick(); exp_cnt++;
        check("ill_exc", 64'(wb_exception), 64'd1);
        check("ill_we",  64'(wb_write_enable), 64'd0);
        check("ill_reg", 64'(wb_write_register), 64'd2);

        load(5'd2, 3'b011, 3'd4, 64'h55);
        tick();
        check("ldmis_exc", 64'(wb_exception), 64'd1);

        // reserved select: no write, data 0, not an exception
        drive(1'b1, 5'd3, 1'b1, 2'b11, 64'h5, 64'h0, 3'd0, 3'd0, 64'h9);
        tick();
        check("rsv_we",   64'(wb_write_enable), 64'd0);
        check("rsv_data", wb_write_data, 64'd0);
        check("rsv_exc",  64'(wb_exception), 64'd0);
        check("rsv_cnt",  retire_count, exp_cnt);

        // ALU op for the following misaligned-but-ALU check and the stall hold
        drive(1'b1, 5'd7, 1'b1, 2'b00, 64'hAAAA, 64'h0, 3'd7, 3'd3, 64'h0);
        tick(); exp_cnt++;
        check("alu_we",   64'(wb_write_enable), 64'd1);
        check("alu_exc",  64'(wb_exception), 64'd0);
        check("alu_data", wb_write_data, 64'hAAAA);

        // stall for 3 cycles: latch and counter hold
        stall = 1'b1;
        drive(1'b1, 5'd9, 1'b1, 2'b00, 64'h5555, 64'h0, 3'd0, 3'd0, 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_data", wb_write_data, 64'hAAAA);
            check("stall_reg",  64'(wb_write_register), 64'd7);
            check("stall_cnt",  retire_count, exp_cnt);
        end
        stall = 1'b0;
        bubble();
        tick(); exp_cnt++;
        check("unstall_cnt",   retire_count, exp_cnt);
        check("unstall_valid", 64'(wb_valid), 64'd0);

        // stall and flush together: bubble wins, stalled slot not counted
        drive(1'b1, 5'd4, 1'b1, 2'b00, 64'h44, 64'h0, 3'd0, 3'd0, 64'h0);
        tick();
        check("pre_flush_valid", 64'(wb_valid), 64'd1);
        stall = 1'b1;
        flush = 1'b1;
        drive(1'b1, 5'd10, 1'b1, 2'b00, 64'h10, 64'h0, 3'd0, 3'd0, 64'h0);
        tick();
        check("flush_valid", 64'(wb_valid), 64'd0);
        check("flush_we",    64'(wb_write_enable), 64'd0);
        stall = 1'b0;
        flush = 1'b0;
        bubble();
        tick();
        check("flush_cnt", retire_count, exp_cnt);

        // counter wrap
        force dut.retire_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.retire_q;
        #1;
        check("preset_cnt", retire_count, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(1'b1, 5'd5, 1'b1, 2'b00, 64'h1, 64'h0, 3'd0, 3'd0, 64'h0);
        tick();
        check("wrap_pre", retire_count, 64'hFFFF_FFFF_FFFF_FFFF);
        bubble();
        tick();
        check("wrap_cnt", retire_count, 64'd0);

        // asynchronous reset mid-stream
        drive(1'b1, 5'd6, 1'b1, 2'b10, 64'h66, 64'h0, 3'd0, 3'd0, 64'h1000);
        tick();
        check("pre_rst_we", 64'(wb_write_enable), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        tick();
        rst = 1'b0;
        bubble();
        tick();
        check_zero("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
